pipeline_ctrl_unit: RTL and testbench

Central stall/flush/trap sequencer for the 5-stage pipeline. It drives write-enables and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC-source select. It resolves load-use hazards, branch/jump redirects and memory wait states. A trap FSM converts EX-stage exceptions and external interrupts into a single MEMWB_X entry cycle, which saves the EX/MEM PC and vectors fetch to the handler.

---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl_unit_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl_unit.sv | 179 +++++++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline control unit.
//   state_t          trap sequencer states
//   PCSEL_*          encodings of the PC-source select
//   memwb_ctrl_t     MEM/WB control word layout
//   MEMWB_TRAP_CTRL  control word the MEM/WB register loads on a trap bubble
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IRQ_WAIT = 2'd1,
        ST_EXC_MARK = 2'd2,
        ST_HANDLER  = 2'd3
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;  // PC + 4
    localparam logic [1:0] PCSEL_BR  = 2'b01;  // branch target
    localparam logic [1:0] PCSEL_JMP = 2'b10;  // jump target
    localparam logic [1:0] PCSEL_VEC = 2'b11;  // trap vector

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic save_pc;
    } memwb_ctrl_t;

    // Trap bubble: writes no register, but captures the incoming PC as EPC.
    localparam memwb_ctrl_t MEMWB_TRAP_CTRL = '{reg_write: 1'b0, mem_to_reg: 1'b0, save_pc: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// hazard_detect
// Combinational load-use hazard compare between ID/EX and IF/ID.
//   idex_memread  ID/EX instruction is a load
//   idex_rt       load destination register
//   ifid_rs/rt    source specifiers of the instruction in IF/ID
//   ifid_uses_rt  IF/ID instruction actually reads rt
//   load_use      1 = IF/ID must wait one cycle for the load result
module hazard_detect
#(
    parameter int REG_W = 5
)
(
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    output logic             load_use
);

    // Register 0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = idex_memread
                    & (idex_rt != '0)
                    & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit
// Stall/flush/trap sequencer for the 5-stage pipeline.
// Inputs : CLK, reset (sync, active-high), mem_ready, load-use operands,
//          id_jump, id_eret, ex_branch_taken, ex_exc, exmem_valid, irq, irq_en.
// Outputs: pc_write, pc_sel, IFID_write, IFID/IDEX/EXMEM_flush, hold_back,
//          MEMWB_X (trap bubble into MEM/WB), irq_ack (registered pulse),
//          in_handler (registered), dbg_state_o / dbg_wait_cnt_o (FSM state).
// Per-cycle priority: mem stall > trap entry > ex_exc > branch > load-use > jump.
// The pipeline has no valid/ready handshake here: mem_ready=0 simply freezes
// everything, including this FSM.
module pipeline_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int WAIT_MAX = 8
)
(
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        mem_ready,
    input  logic                        idex_memread,
    input  logic [REG_W-1:0]            idex_rt,
    input  logic [REG_W-1:0]            ifid_rs,
    input  logic [REG_W-1:0]            ifid_rt,
    input  logic                        ifid_uses_rt,
    input  logic                        id_jump,
    input  logic                        id_eret,
    input  logic                        ex_branch_taken,
    input  logic                        ex_exc,
    input  logic                        exmem_valid,
    input  logic                        irq,
    input  logic                        irq_en,
    output logic                        pc_write,
    output logic [1:0]                  pc_sel,
    output logic                        IFID_write,
    output logic                        IFID_flush,
    output logic                        IDEX_flush,
    output logic                        EXMEM_flush,
    output logic                        hold_back,
    output logic                        MEMWB_X,
    output logic                        irq_ack,
    output logic                        in_handler,
    output state_t                      dbg_state_o,
    output logic [$clog2(WAIT_MAX)-1:0] dbg_wait_cnt_o
);

    localparam int                CNT_W    = $clog2(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               irq_ack_q;
    logic               in_handler_q;

    logic               load_use;
    logic               irq_req;
    logic               cnt_last;
    logic               trap_entry;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .load_use     (load_use)
    );

    assign irq_req  = irq & irq_en;
    assign cnt_last = (wait_cnt_q == CNT_LAST);

    // An interrupt waits for a real instruction in EX/MEM so the saved PC is
    // meaningful, but gives up waiting after WAIT_MAX cycles. It also yields
    // to an exception or taken branch in EX, which own the redirect that cycle.
    assign trap_entry = mem_ready &
                        ((state_q == ST_EXC_MARK) |
                         ((state_q == ST_IRQ_WAIT) & irq_req & ~ex_exc & ~ex_branch_taken &
                          (exmem_valid | cnt_last)));

    // Priority mux for the pipeline-register controls.
    always_comb begin
        pc_write    = 1'b1;
        pc_sel      = PCSEL_SEQ;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        hold_back   = 1'b0;
        MEMWB_X     = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
        end else if (!mem_ready) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            hold_back  = 1'b1;
        end else if (trap_entry) begin
            MEMWB_X     = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            pc_sel      = PCSEL_VEC;
        end else if (ex_exc) begin
            // The faulting PC travels on in the EX/MEM bubble; entry happens next cycle.
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            pc_write    = 1'b0;
        end else if (ex_branch_taken) begin
            pc_sel     = PCSEL_BR;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else if (id_jump) begin
            pc_sel     = PCSEL_JMP;
            IFID_flush = 1'b1;
        end
    end

    // Trap FSM. Frozen while memory is busy, except that irq_ack always
    // drops after one cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            irq_ack_q    <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            if (mem_ready) begin
                if (trap_entry) begin
                    state_q      <= ST_HANDLER;
                    in_handler_q <= 1'b1;
                    irq_ack_q    <= (state_q == ST_IRQ_WAIT);
                end else if (ex_exc) begin
                    state_q      <= ST_EXC_MARK;
                    in_handler_q <= 1'b0;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (irq_req) begin
                                state_q    <= ST_IRQ_WAIT;
                                wait_cnt_q <= '0;
                            end
                        end
                        ST_IRQ_WAIT: begin
                            if (!irq_req) begin
                                state_q <= ST_RUN;
                            end else if (!cnt_last) begin
                                wait_cnt_q <= wait_cnt_q + 1'b1;
                            end
                        end
                        ST_HANDLER: begin
                            if (id_eret) begin
                                state_q      <= ST_RUN;
                                in_handler_q <= 1'b0;
                            end
                        end
                        ST_EXC_MARK: begin
                            // Always leaves through trap_entry when memory is ready.
                        end
                        default: begin
                            state_q <= ST_RUN;
                        end
                    endcase
                end
            end
        end
    end

    assign irq_ack        = irq_ack_q;
    assign in_handler     = in_handler_q;
    assign dbg_state_o    = state_q;
    assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
module tb_pipeline_ctrl_unit;
    import pipeline_ctrl_pkg::*;

    // ctl bit order: pc_write, pc_sel[1:0], IFID_write, IFID_flush,
    //                IDEX_flush, EXMEM_flush, hold_back, MEMWB_X
    localparam logic [8:0] C_ZERO  = 9'b0_00_0_0_0_0_0_0;
    localparam logic [8:0] C_DEF   = 9'b1_00_1_0_0_0_0_0;
    localparam logic [8:0] C_STALL = 9'b0_00_0_0_0_0_1_0;
    localparam logic [8:0] C_LU    = 9'b0_00_0_0_1_0_0_0;
    localparam logic [8:0] C_BR    = 9'b1_01_1_1_1_0_0_0;
    localparam logic [8:0] C_JMP   = 9'b1_10_1_1_0_0_0_0;
    localparam logic [8:0] C_TRAP  = 9'b1_11_1_1_1_1_0_1;
    localparam logic [8:0] C_EXC   = 9'b0_00_1_1_1_1_0_0;

    logic       CLK = 1'b0;
    logic       reset;
    logic       mem_ready, idex_memread, ifid_uses_rt;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       id_jump, id_eret, ex_branch_taken, ex_exc, exmem_valid, irq, irq_en;
    logic       pc_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_flush;
    logic       hold_back, MEMWB_X, irq_ack, in_handler;
    logic [1:0] pc_sel;
    state_t     dbg_state;
    logic [2:0] dbg_wait_cnt;
    logic [8:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl_unit #(.REG_W(5), .WAIT_MAX(8)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .mem_ready       (mem_ready),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .ifid_uses_rt    (ifid_uses_rt),
        .id_jump         (id_jump),
        .id_eret         (id_eret),
        .ex_branch_taken (ex_branch_taken),
        .ex_exc          (ex_exc),
        .exmem_valid     (exmem_valid),
        .irq             (irq),
        .irq_en          (irq_en),
        .pc_write        (pc_write),
        .pc_sel          (pc_sel),
        .IFID_write      (IFID_write),
        .IFID_flush      (IFID_flush),
        .IDEX_flush      (IDEX_flush),
        .EXMEM_flush     (EXMEM_flush),
        .hold_back       (hold_back),
        .MEMWB_X         (MEMWB_X),
        .irq_ack         (irq_ack),
        .in_handler      (in_handler),
        .dbg_state_o     (dbg_state),
        .dbg_wait_cnt_o  (dbg_wait_cnt)
    );

    assign ctl = {pc_write, pc_sel, IFID_write, IFID_flush, IDEX_flush, EXMEM_flush, hold_back, MEMWB_X};

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_ready       = 1'b1;
        idex_memread    = 1'b0;
        idex_rt         = 5'd0;
        ifid_rs         = 5'd0;
        ifid_rt         = 5'd0;
        ifid_uses_rt    = 1'b0;
        id_jump         = 1'b0;
        id_eret         = 1'b0;
        ex_branch_taken = 1'b0;
        ex_exc          = 1'b0;
        exmem_valid     = 1'b0;
        irq             = 1'b0;
        irq_en          = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        idle();
        reset   = 1'b1;
        id_jump = 1'b1;
        ex_exc  = 1'b1;
        settle();
        chk("reset_ctl_zero", ctl, C_ZERO);
        tick();
        settle();
        chk("reset_state", 9'(dbg_state), 9'(ST_RUN));
        chk("reset_irq_ack", 9'(irq_ack), 9'd0);
        chk("reset_in_handler", 9'(in_handler), 9'd0);
        chk("reset_ctl_zero2", ctl, C_ZERO);
        tick();
        reset = 1'b0;
        idle();
        settle();
        chk("idle_default", ctl, C_DEF);

        // ---------------- load-use ----------------
        tick();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        settle();
        chk("lu_rs_stall", ctl, C_LU);
        tick();
        idex_memread = 1'b0;   // the bubble now sits in ID/EX
        settle();
        chk("lu_one_cycle_only", ctl, C_DEF);
        tick();
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        settle();
        chk("lu_r0_no_stall", ctl, C_DEF);
        tick();
        idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused", ctl, C_DEF);
        ifid_uses_rt = 1'b1;
        settle();
        chk("lu_rt_used", ctl, C_LU);

        // ---------------- branch / jump priority ----------------
        tick();
        ex_branch_taken = 1'b1; id_jump = 1'b1;   // load-use still active
        settle();
        chk("br_masks_lu_jmp", ctl, C_BR);
        tick();
        idle();
        id_jump = 1'b1;
        settle();
        chk("jump_alone", ctl, C_JMP);
        ex_branch_taken = 1'b1; mem_ready = 1'b0;
        settle();
        chk("memstall_over_branch", ctl, C_STALL);

        // ---------------- IRQ wait with memory stall ----------------
        tick();
        idle();
        irq = 1'b1; irq_en = 1'b1;
        settle();
        chk("irq_run_cycle", ctl, C_DEF);
        tick();
        chk("irq_wait_state", 9'(dbg_state), 9'(ST_IRQ_WAIT));
        chk("irq_wait_cnt0", 9'(dbg_wait_cnt), 9'd0);
        chk("irq_wait_novalid", ctl, C_DEF);
        tick();
        mem_ready = 1'b0; exmem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_hold", ctl, C_STALL);
            chk("stall_cnt_frozen", 9'(dbg_wait_cnt), 9'd1);
            chk("stall_state_frozen", 9'(dbg_state), 9'(ST_IRQ_WAIT));
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("irq_entry_valid", ctl, C_TRAP);
        tick();
        chk("irq_ack_pulse", 9'(irq_ack), 9'd1);
        chk("in_handler_set", 9'(in_handler), 9'd1);
        chk("handler_ignores_irq", ctl, C_DEF);
        tick();
        chk("irq_ack_cleared", 9'(irq_ack), 9'd0);
        chk("handler_stays", 9'(dbg_state), 9'(ST_HANDLER));
        irq = 1'b0; id_eret = 1'b1; mem_ready = 1'b0;
        tick();
        chk("eret_frozen_by_stall", 9'(dbg_state), 9'(ST_HANDLER));
        mem_ready = 1'b1;
        tick();
        chk("eret_to_run", 9'(dbg_state), 9'(ST_RUN));
        chk("in_handler_clear", 9'(in_handler), 9'd0);

        // ---------------- forced entry after WAIT_MAX ----------------
        idle();
        irq = 1'b1; irq_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("forced_wait_ctl", ctl, C_DEF);
            chk("forced_wait_cnt", 9'(dbg_wait_cnt), 9'(i));
            tick();
        end
        settle();
        chk("forced_entry", ctl, C_TRAP);
        chk("forced_entry_cnt", 9'(dbg_wait_cnt), 9'd7);
        tick();
        irq = 1'b0;
        chk("forced_irq_ack", 9'(irq_ack), 9'd1);
        chk("forced_in_handler", 9'(in_handler), 9'd1);
        id_eret = 1'b1;
        tick();
        idle();
        chk("forced_eret_run", 9'(dbg_state), 9'(ST_RUN));

        // ---------------- exception in RUN ----------------
        ex_exc = 1'b1;
        settle();
        chk("exc_cycle1", ctl, C_EXC);
        tick();
        ex_exc = 1'b0;
        chk("exc_mark_state", 9'(dbg_state), 9'(ST_EXC_MARK));
        settle();
        chk("exc_cycle2_entry", ctl, C_TRAP);
        tick();
        chk("exc_no_ack", 9'(irq_ack), 9'd0);
        chk("exc_in_handler", 9'(in_handler), 9'd1);
        tick();
        chk("exc_no_ack_later", 9'(irq_ack), 9'd0);
        id_eret = 1'b1;
        tick();
        idle();
        chk("exc_eret_run", 9'(dbg_state), 9'(ST_RUN));

        // ---------------- irq dropped while waiting ----------------
        irq = 1'b1; irq_en = 1'b1;
        tick();
        chk("drop_in_wait", 9'(dbg_state), 9'(ST_IRQ_WAIT));
        irq = 1'b0;
        settle();
        chk("drop_ctl", ctl, C_DEF);
        tick();
        chk("drop_back_run", 9'(dbg_state), 9'(ST_RUN));
        chk("drop_no_ack", 9'(irq_ack), 9'd0);

        // ---------------- reset while in HANDLER ----------------
        ex_exc = 1'b1;
        tick();
        ex_exc = 1'b0;
        tick();
        chk("pre_reset_handler", 9'(dbg_state), 9'(ST_HANDLER));
        reset = 1'b1; irq = 1'b1; irq_en = 1'b1; id_jump = 1'b1; ex_branch_taken = 1'b1;
        settle();
        chk("reset_mid_ctl_zero", ctl, C_ZERO);
        tick();
        chk("reset_mid_state", 9'(dbg_state), 9'(ST_RUN));
        chk("reset_mid_in_handler", 9'(in_handler), 9'd0);
        chk("reset_mid_no_ack", 9'(irq_ack), 9'd0);
        idle();
        reset = 1'b0;
        settle();
        chk("after_reset_default", ctl, C_DEF);
        tick();
        chk("after_reset_no_ack", 9'(irq_ack), 9'd0);
        chk("after_reset_run", 9'(dbg_state), 9'(ST_RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
